bus_arbiter4: RTL and testbench

- Round-robin arbiter sharing one WIDTH-bit result bus among four requesters, for example functional units competing for a register-file write port.
- Owns the 2-bit select of a mux4input instance (out = in0..in3 by address) and drives a valid/ready handshake toward the single consumer.
- Supports bursts: a granted requester keeps the bus for up to MAX_BURST accepted words, then the grant rotates.

---
 rtl/bus_arbiter4.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter4.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter4.sv
// Four-way round-robin arbiter that shares one result bus through a mux4input,
// with valid/ready handshake toward the consumer and bursts of up to MAX_BURST words.

module mux4input #(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    output logic [WIDTH-1:0] out
);
    always_comb begin
        case (addr)
            2'd0:    out = in0;
            2'd1:    out = in1;
            2'd2:    out = in2;
            default: out = in3;
        endcase
    end
endmodule

module bus_arbiter4 #(
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       ack,
    output logic             busy
);
    localparam int CW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_nx;
    logic [1:0]      sel_nx;
    logic [1:0]      last, last_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [1:0]      winner;
    logic [WIDTH-1:0] mux_out;

    mux4input #(.WIDTH(WIDTH)) u_mux (
        .addr (sel),
        .in0  (in0),
        .in1  (in1),
        .in2  (in2),
        .in3  (in3),
        .out  (mux_out)
    );

    // Scan last+1 .. last+4 so the previous owner is considered last.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last;
        found  = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        ack       = '0;
        busy      = 1'b0;
        state_nx  = state;
        sel_nx    = sel;
        last_nx   = last;
        cnt_nx    = cnt;

        case (state)
            IDLE: begin
                if (req != '0) begin
                    sel_nx   = winner;
                    cnt_nx   = '0;
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                busy      = 1'b1;
                out_valid = req[sel];
                if (out_valid) begin
                    out_data = mux_out;
                    if (out_ready) begin
                        ack = 4'b0001 << sel;
                        if (cnt == CNT_LAST) begin
                            state_nx = IDLE;
                            last_nx  = sel;
                            cnt_nx   = '0;
                        end else begin
                            cnt_nx = cnt + CW'(1);
                        end
                    end
                end else begin
                    state_nx = IDLE;
                    last_nx  = sel;
                    cnt_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Reset masks the handshake combinationally, even mid-burst.
        if (reset) begin
            out_valid = 1'b0;
            out_data  = '0;
            ack       = '0;
            busy      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sel   <= 2'd0;
            last  <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            last  <= last_nx;
            cnt   <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_bus_arbiter4.sv
// Bench for bus_arbiter4: two instances (MAX_BURST 4 and 1) share stimulus and are
// compared every cycle against a grant/beat-count reference model.

module tb_bus_arbiter4;
    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic        out_ready;
    logic [31:0] din [4];

    logic        ov4, ov1;
    logic [31:0] od4, od1;
    logic [1:0]  sel4, sel1;
    logic [3:0]  ack4, ack1;
    logic        busy4, busy1;

    int n_cmp = 0;
    int n_err = 0;

    int mb      [2] = '{4, 1};
    int m_owner [2];
    int m_beats [2];
    int m_last  [2];
    int m_sel   [2];

    bus_arbiter4 #(.WIDTH(32), .MAX_BURST(4)) dut4 (
        .clk(clk), .reset(reset), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .out_ready(out_ready), .out_valid(ov4), .out_data(od4),
        .sel(sel4), .ack(ack4), .busy(busy4)
    );

    bus_arbiter4 #(.WIDTH(32), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset(reset), .req(req),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .out_ready(out_ready), .out_valid(ov1), .out_data(od1),
        .sel(sel1), .ack(ack1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_beats[i] = 0;
            m_last[i]  = 3;
            m_sel[i]   = 0;
        end
    endtask

    // Reference: who owns the bus and how many words it has delivered.
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_owner[i] = -1; m_beats[i] = 0; m_last[i] = 3; m_sel[i] = 0;
            end else if (m_owner[i] < 0) begin
                if (req != 4'b0000) begin
                    for (int k = 1; k <= 4; k++) begin
                        int idx;
                        idx = (m_last[i] + k) % 4;
                        if (m_owner[i] < 0 && req[idx]) begin
                            m_owner[i] = idx; m_sel[i] = idx; m_beats[i] = 0;
                        end
                    end
                end
            end else if (!req[m_owner[i]]) begin
                m_last[i] = m_owner[i]; m_owner[i] = -1; m_beats[i] = 0;
            end else if (out_ready) begin
                m_beats[i]++;
                if (m_beats[i] == mb[i]) begin
                    m_last[i] = m_owner[i]; m_owner[i] = -1; m_beats[i] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            logic        eb, ev;
            logic [31:0] ed;
            logic [3:0]  ea;
            eb = 1'b0; ev = 1'b0; ed = '0; ea = '0;
            if (!reset && m_owner[i] >= 0) begin
                eb = 1'b1;
                ev = req[m_owner[i]];
                if (ev) begin
                    ed = din[m_owner[i]];
                    if (out_ready) ea = 4'(1 << m_owner[i]);
                end
            end
            if (i == 0) begin
                check("valid4", 32'(ov4), 32'(ev));
                check("data4", od4, ed);
                check("ack4", 32'(ack4), 32'(ea));
                check("busy4", 32'(busy4), 32'(eb));
                check("sel4", 32'(sel4), 32'(m_sel[0]));
            end else begin
                check("valid1", 32'(ov1), 32'(ev));
                check("data1", od1, ed);
                check("ack1", 32'(ack1), 32'(ea));
                check("busy1", 32'(busy1), 32'(eb));
                check("sel1", 32'(sel1), 32'(m_sel[1]));
            end
        end
    endtask

    // Called at the negedge: apply inputs, then compare away from the active edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic rdy);
        reset = r; req = rq; out_ready = rdy;
        #1;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic int ack_index(input logic [3:0] a);
        for (int k = 0; k < 4; k++) if (a[k]) return k;
        return -1;
    endfunction

    initial begin
        int grants[$];
        int exp_rot[5];
        int exp_fair[4];
        int nack;
        logic [3:0] prev;

        reset = 1'b1; req = '0; out_ready = 1'b0;
        for (int k = 0; k < 4; k++) din[k] = '0;
        @(posedge clk);
        model_reset();
        @(negedge clk);

        // Reset state
        drive(1, 4'b0000, 1);
        check("reset_sel", 32'(sel4), 32'd0);
        check("reset_busy", 32'(busy4), 32'd0);
        advance();

        // Single beat
        din[0] = 32'hFFFFFFFF;
        drive(0, 4'b0001, 1); check("single_c1_valid", 32'(ov4), 32'd0); advance();
        drive(0, 4'b0001, 1);
        check("single_c2_data", od4, 32'hFFFFFFFF);
        check("single_c2_ack", 32'(ack4), 32'h1);
        advance();
        drive(0, 4'b0000, 1);
        check("single_c3_busy", 32'(busy4), 32'd1);
        check("single_c3_valid", 32'(ov4), 32'd0);
        advance();
        drive(0, 4'b0000, 1); check("single_c4_busy", 32'(busy4), 32'd0); advance();

        // Full rotation from reset: grants 0,1,2,3,0 with 4 beats each
        din[0] = 32'h144CAB32; din[1] = 32'hA3C972C4; din[2] = 32'h55555555; din[3] = 32'hAAAAAAAA;
        drive(1, 4'b0000, 1); advance();
        grants.delete(); nack = 0; prev = '0;
        for (int c = 0; c < 25; c++) begin
            drive(0, 4'b1111, 1);
            if (ack4 != 4'b0000) nack++;
            if (ack4 != 4'b0000 && prev == 4'b0000) grants.push_back(ack_index(ack4));
            prev = ack4;
            advance();
        end
        exp_rot = '{0, 1, 2, 3, 0};
        check("rot_ngrants", 32'(grants.size()), 32'd5);
        check("rot_nacks", 32'(nack), 32'd20);
        for (int g = 0; g < 5 && g < grants.size(); g++)
            check($sformatf("rot_grant%0d", g), 32'(grants[g]), 32'(exp_rot[g]));

        // Stall on requester 2
        din[2] = 32'hD132AB67;
        drive(1, 4'b0000, 0); advance();
        drive(0, 4'b0100, 0); advance();
        for (int c = 0; c < 10; c++) begin
            drive(0, 4'b0100, 0);
            check("stall_valid", 32'(ov4), 32'd1);
            check("stall_data", od4, 32'hD132AB67);
            check("stall_ack", 32'(ack4), 32'd0);
            advance();
        end
        drive(0, 4'b0100, 1); check("stall_release_ack", 32'(ack4), 32'b0100); advance();
        for (int c = 0; c < 3; c++) begin
            drive(0, 4'b0100, 1); check("stall_rest_ack", 32'(ack4), 32'b0100); advance();
        end
        drive(0, 4'b0100, 1); check("stall_burst_end", 32'(busy4), 32'd0); advance();

        // Early withdraw: requester 0 leaves after 2 beats, requester 1 follows
        din[0] = 32'h01234567; din[1] = 32'h89ABCDEF;
        drive(1, 4'b0000, 1); advance();
        drive(0, 4'b0011, 1); advance();
        drive(0, 4'b0011, 1); advance();
        drive(0, 4'b0011, 1); advance();
        drive(0, 4'b0010, 1); check("withdraw_valid", 32'(ov4), 32'd0); advance();
        drive(0, 4'b0010, 1); check("withdraw_idle", 32'(busy4), 32'd0); advance();
        drive(0, 4'b0010, 1);
        check("withdraw_sel", 32'(sel4), 32'd1);
        check("withdraw_data", od4, 32'h89ABCDEF);
        advance();

        // Reset during 2nd beat of requester 3
        drive(1, 4'b0000, 1); advance();
        drive(0, 4'b1000, 1); advance();
        drive(0, 4'b1000, 1); advance();
        drive(1, 4'b1000, 1);
        check("rstmid_valid", 32'(ov4), 32'd0);
        check("rstmid_ack", 32'(ack4), 32'd0);
        advance();
        drive(0, 4'b1010, 1); check("rstmid_idle", 32'(busy4), 32'd0); advance();
        drive(0, 4'b1010, 1); check("rstmid_sel", 32'(sel4), 32'd1); advance();

        // Fairness on the single-beat instance: last=0, then req=1001 held
        din[0] = 32'h0000AAAA; din[3] = 32'h3333BBBB;
        drive(1, 4'b0000, 1); advance();
        drive(0, 4'b0001, 1); advance();
        drive(0, 4'b0001, 1); advance();
        grants.delete();
        for (int c = 0; c < 8; c++) begin
            drive(0, 4'b1001, 1);
            if (ack1 != 4'b0000) grants.push_back(ack_index(ack1));
            advance();
        end
        exp_fair = '{3, 0, 3, 0};
        check("fair_ngrants", 32'(grants.size()), 32'd4);
        for (int g = 0; g < 4 && g < grants.size(); g++)
            check($sformatf("fair_grant%0d", g), 32'(grants[g]), 32'(exp_fair[g]));

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 4; k++) din[k] = $urandom;
            drive(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
